// File: rtl/connect8_pkg.sv
// Shared constants and FSM state type for the block-placement sequencer.
// Exports GRID_N, SCORE_W, SAT_LIM, state_t and popcount8(); FLASH state exists only with PLACE_SEQ_FLASH_EN.
package connect8_pkg;

   localparam int GRID_N  = 8;
   localparam int SCORE_W = 8;
   localparam int SAT_LIM = 255;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_PAINT  = 3'd2,
      S_SCAN   = 3'd3,
      S_COMMIT = 3'd4,
      S_DONE   = 3'd5
`ifdef PLACE_SEQ_FLASH_EN
      , S_FLASH = 3'd6
`endif
   } state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int k = 0; k < 8; k++) n = n + 4'(v[k]);
      return n;
   endfunction

endpackage

// File: rtl/popcount64.sv
// Combinational population count of a 64-bit board/shape bitmap.
// Ports: bits (in, 64) -> count (out, 7).
module popcount64 (
   input  logic [63:0] bits,
   output logic [6:0]  count
);

   always_comb begin
      count = '0;
      for (int k = 0; k < 64; k++) count = count + 7'(bits[k]);
   end

endmodule

// File: rtl/place_sequencer.sv
// Places a block on an 8x8 board, clears full rows/columns and scores the move.
// Ports: clk, reset (sync, active-low), start, blk_sel, blk_shape, blk_x, blk_y,
//   grid_in -> busy, done, rejected, grid_out, grid_we, score_add, consume, clr_mask.
// Macro PLACE_SEQ_FLASH_EN adds a FLASH state holding clr_mask for FLASH_LEN cycles.
module place_sequencer #(
`ifdef PLACE_SEQ_FLASH_EN
   parameter int FLASH_LEN = 4,
`endif
   parameter int GRID_N = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  blk_sel,
   input  logic [63:0] blk_shape,
   input  logic [2:0]  blk_x,
   input  logic [2:0]  blk_y,
   input  logic [63:0] grid_in,
   output logic        busy,
   output logic        done,
   output logic        rejected,
   output logic [63:0] grid_out,
   output logic        grid_we,
   output logic [7:0]  score_add,
   output logic [2:0]  consume,
   output logic [63:0] clr_mask
);
   import connect8_pkg::*;

   state_t state, state_n;

   logic [2:0]  i_q, i_n;
   logic [1:0]  sel_q;
   logic [63:0] shape_q;
   logic [2:0]  x_q, y_q;
   logic [63:0] grid_q, grid_n;
   logic [7:0]  rf_q, rf_n, cf_q, cf_n;
   logic        rej_q, rej_n;
   logic [7:0]  score_q, score_n;

   logic        done_n, rej_o_n, we_n;
   logic [63:0] gout_n, clr_n;
   logic [2:0]  cons_n;
   logic [7:0]  sadd_n;

   logic [63:0] shifted, mask;
   logic        oob, illegal, row_hit, col_hit;
   logic [3:0]  sr, sc, nr, nc;
   logic [5:0]  k6;
   logic [6:0]  pc;
   logic [8:0]  s9;
   logic        accept;

`ifdef PLACE_SEQ_FLASH_EN
   logic [7:0]  fcnt_q, fcnt_n;
`endif

   popcount64 u_pc (.bits(shape_q), .count(pc));

   assign accept = (state == S_IDLE) && start;
   assign busy   = (state != S_IDLE);

   // Block shifted to its origin; any set cell past the edge flags oob.
   always_comb begin
      shifted = '0;
      oob     = 1'b0;
      sr      = '0;
      sc      = '0;
      k6      = '0;
      for (int r = 0; r < GRID_N; r++) begin
         for (int c = 0; c < GRID_N; c++) begin
            sr = {1'b0, y_q} + 4'(r);
            sc = {1'b0, x_q} + 4'(c);
            k6 = {3'(r), 3'(c)};
            if (shape_q[k6]) begin
               if (sr[3] | sc[3]) oob = 1'b1;
               else shifted[{sr[2:0], sc[2:0]}] = 1'b1;
            end
         end
      end
   end

   assign illegal = (shape_q == '0) || (sel_q == 2'd0) || oob
                  || ((shifted & grid_q) != '0);

   // One row and one column tested per SCAN cycle.
   always_comb begin
      rf_n    = rf_q;
      cf_n    = cf_q;
      row_hit = &grid_q[{i_q, 3'b000} +: 8];
      col_hit = 1'b1;
      for (int r = 0; r < GRID_N; r++)
         col_hit = col_hit & grid_q[{3'(r), i_q}];
      if (state == S_IDLE) begin
         rf_n = '0;
         cf_n = '0;
      end else if (state == S_SCAN) begin
         rf_n[i_q] = row_hit;
         cf_n[i_q] = col_hit;
      end
   end

   // Built from next-cycle line flags so the last SCAN cycle sees row/col 7.
   always_comb begin
      mask = '0;
      for (int r = 0; r < GRID_N; r++)
         for (int c = 0; c < GRID_N; c++)
            mask[{3'(r), 3'(c)}] = rf_n[3'(r)] | cf_n[3'(c)];
   end

   assign nr = popcount8(rf_q);
   assign nc = popcount8(cf_q);
   assign s9 = 9'(pc)
             + 9'(SCORE_W) * (9'(nr) + 9'(nc))
             + 9'(nr) * 9'(nc);

   always_comb begin
      state_n = state;
      i_n     = i_q;
      grid_n  = grid_q;
      rej_n   = rej_q;
      score_n = score_q;
      done_n  = 1'b0;
      rej_o_n = 1'b0;
      we_n    = 1'b0;
      gout_n  = '0;
      cons_n  = '0;
      sadd_n  = '0;
      clr_n   = '0;
`ifdef PLACE_SEQ_FLASH_EN
      fcnt_n  = fcnt_q;
`endif
      unique case (state)
         S_IDLE: begin
            i_n = '0;
            if (start) begin
               state_n = S_CHECK;
               rej_n   = 1'b0;
               score_n = '0;
            end
         end
         S_CHECK: begin
            if (illegal) begin
               state_n = S_DONE;
               rej_n   = 1'b1;
            end else begin
               state_n = S_PAINT;
            end
         end
         S_PAINT: begin
            grid_n  = grid_q | shifted;
            state_n = S_SCAN;
         end
         S_SCAN: begin
            i_n = i_q + 3'd1;
            if (i_q == 3'd7) begin
`ifdef PLACE_SEQ_FLASH_EN
               if (mask != '0) begin
                  state_n = S_FLASH;
                  clr_n   = mask;
                  fcnt_n  = '0;
               end else begin
                  state_n = S_COMMIT;
               end
`else
               state_n = S_COMMIT;
`endif
            end
         end
`ifdef PLACE_SEQ_FLASH_EN
         S_FLASH: begin
            fcnt_n = fcnt_q + 8'd1;
            if (fcnt_q == 8'(FLASH_LEN - 1)) begin
               state_n = S_COMMIT;
            end else begin
               clr_n = mask;
            end
         end
`endif
         S_COMMIT: begin
            we_n    = 1'b1;
            gout_n  = grid_q & ~mask;
            cons_n  = 3'b001 << (sel_q - 2'd1);
            score_n = (s9 > 9'(SAT_LIM)) ? 8'(SAT_LIM) : s9[7:0];
            state_n = S_DONE;
         end
         S_DONE: begin
            done_n  = 1'b1;
            rej_o_n = rej_q;
            sadd_n  = rej_q ? 8'd0 : score_q;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         i_q       <= '0;
         rej_q     <= 1'b0;
         score_q   <= '0;
         rf_q      <= '0;
         cf_q      <= '0;
         done      <= 1'b0;
         rejected  <= 1'b0;
         grid_we   <= 1'b0;
         grid_out  <= '0;
         consume   <= '0;
         score_add <= '0;
         clr_mask  <= '0;
`ifdef PLACE_SEQ_FLASH_EN
         fcnt_q    <= '0;
`endif
      end else begin
         state     <= state_n;
         i_q       <= i_n;
         rej_q     <= rej_n;
         score_q   <= score_n;
         rf_q      <= rf_n;
         cf_q      <= cf_n;
         done      <= done_n;
         rejected  <= rej_o_n;
         grid_we   <= we_n;
         grid_out  <= gout_n;
         consume   <= cons_n;
         score_add <= sadd_n;
         clr_mask  <= clr_n;
`ifdef PLACE_SEQ_FLASH_EN
         fcnt_q    <= fcnt_n;
`endif
      end
   end

   // Request operands are captured once, on the accepting edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_q   <= '0;
         shape_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         grid_q  <= '0;
      end else if (accept) begin
         sel_q   <= blk_sel;
         shape_q <= blk_shape;
         x_q     <= blk_x;
         y_q     <= blk_y;
         grid_q  <= grid_in;
      end else begin
         grid_q  <= grid_n;
      end
   end

endmodule

// File: doc/place_sequencer.md
PLACE_SEQUENCER -- requirements
Module: place_sequencer

Interface
REQ-001 SHALL have parameter FLASH_LEN, default 4, giving the number of cycles the clear mask is held (only when the Configuration macro is defined).
REQ-002 SHALL have parameter GRID_N, default 8, giving the board edge length; only 8 is supported.
REQ-003 SHALL have: clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 SHALL have: reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have: start  input  1  single-cycle request to place the selected block.
REQ-006 SHALL have: blk_sel  input  2  slot index 1..3; the value 0 is illegal.
REQ-007 SHALL have: blk_shape  input  64  block bitmap, bit r*8+c.
REQ-008 SHALL have: blk_x, blk_y  input  3 each  placement origin.
REQ-009 SHALL have: grid_in  input  64  current board.
REQ-010 SHALL have: busy  output  1  high from the cycle after start is accepted until done.
REQ-011 SHALL have: done  output  1  one-cycle pulse ending every accepted request.
REQ-012 SHALL have: rejected  output  1  qualifies done; high means the placement was illegal.
REQ-013 SHALL have: grid_out  output  64  new board, valid while grid_we is high.
REQ-014 SHALL have: grid_we  output  1  one-cycle board write strobe.
REQ-015 SHALL have: score_add  output  8  points for this placement, valid with done.
REQ-016 SHALL have: consume  output  3  one-hot slot-clear pulse, issued with grid_we.
REQ-017 SHALL have: clr_mask  output  64  cells being cleared, non-zero only in FLASH.

Function
REQ-018 SHALL run the states IDLE -> CHECK -> PAINT -> SCAN -> COMMIT -> DONE; FLASH sits between SCAN and COMMIT when the macro is defined.
REQ-019 SHALL accept start only in IDLE; start while busy is ignored and not queued.
REQ-020 SHALL latch blk_sel, blk_shape, blk_x, blk_y and grid_in on the accepting edge; later changes on these inputs have no effect.
REQ-021 SHALL, in CHECK, reject if blk_shape == 0, if blk_sel == 0, if any set cell has x+c > 7 or y+r > 7 (4-bit sums), or if any set cell overlaps the latched grid.
REQ-022 SHALL, on reject, go CHECK -> DONE with done=1 and rejected=1, score_add=0, and no grid_we or consume.
REQ-023 SHALL, in PAINT, OR the shifted block into the working grid (1 cycle).
REQ-024 SHALL, in SCAN, use an index i = 0..7, one per cycle, and test row i and column i of the painted grid, recording row_full[i] and col_full[i] (8 cycles).
REQ-025 SHALL, in COMMIT, clear every cell in a full row or full column and assert grid_we, grid_out and consume[blk_sel-1] for that one cycle.
REQ-026 SHALL compute score_add = popcount(shape) + 8*(nr+nc) + nr*nc, evaluated 9 bits wide and saturated to 255.
REQ-027 SHALL have a fixed latency: with the macro undefined, an accepted request gives done exactly 12 cycles after the start edge; a rejected request gives done 2 cycles after.
REQ-028 SHALL return to IDLE after DONE, so a new start is accepted in the cycle after done.
REQ-029 SHALL handle a fill with no full lines: nr = nc = 0, grid_out equals the painted grid, and score_add = popcount.

Reset
REQ-030 SHALL, while reset=0, force state IDLE, busy=0, done=0, rejected=0, grid_we=0, consume=0, score_add=0, grid_out=0, clr_mask=0 and i=0.
REQ-031 SHALL, when reset occurs mid-operation, abandon the request with no grid_we and no done.

Configuration
REQ-032 SHALL, when PLACE_SEQ_FLASH_EN is defined, insert state FLASH for FLASH_LEN cycles, driving clr_mask with the to-be-cleared cells; FLASH is skipped when the mask is zero, and accepted latency becomes 12+FLASH_LEN when lines clear.
REQ-033 SHALL, when PLACE_SEQ_FLASH_EN is undefined, have no FLASH state and tie clr_mask to 0.

Structure
REQ-034 SHALL place the state enum, GRID_N, the score weight 8 and the saturation limit 255 in the shared package connect8_pkg.
REQ-035 SHALL implement popcount of blk_shape in sub-module popcount64 (combinational, 7-bit output).

Verification
REQ-036 SHALL verify: empty grid, 2x2 shape 0x0303 at (0,0) -> done at +12, rejected=0, grid_out=0x0303, score_add=4, consume=001 (blk_sel=1).
REQ-037 SHALL verify: grid row 0 = 0x3F, 1x2 shape 0x03 at (6,0), blk_sel=2 -> row 0 cleared, grid_out=0, score_add=10, consume=010.
REQ-038 SHALL verify: 1x2 shape at (7,3) -> out of bounds -> done at +2, rejected=1, no grid_we.
REQ-039 SHALL verify: overlapping placement, and start repeated while busy -> single done, extra start ignored.
REQ-040 SHALL verify: reset=0 at SCAN cycle 4 -> no grid_we or done, IDLE on release, next start completes normally.
REQ-041 SHALL verify: with PLACE_SEQ_FLASH_EN, FLASH_LEN=4, a row plus column clear -> clr_mask held 4 cycles, done at +16, score_add = cells + 17.
